// File: rtl/target_seq_pkg.sv
// Shared definitions for the target power sequencer: state encoding,
// register byte map, CTRL bit positions and the count-load helper.
package target_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_OFF  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RST_HOLD = 3'd3
  } seq_state_e;

  localparam int          FIELD_W     = 24;
  localparam logic [15:0] REG_LEN     = 16'd11;

  localparam logic [15:0] BYTE_CTRL   = 16'd0;
  localparam logic [15:0] BYTE_STATUS = 16'd1;
  localparam logic [15:0] BYTE_OFF    = 16'd2;
  localparam logic [15:0] BYTE_SETTLE = 16'd5;
  localparam logic [15:0] BYTE_RST    = 16'd8;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_PWRCYCLE  = 2;
  localparam int CTRL_ARM_AFTER = 3;

  // A programmed count of 0 behaves like 1, so the load value is max(n,1)-1.
  function automatic logic [FIELD_W-1:0] load_value(input logic [FIELD_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/seq_downcounter.sv
// Saturating down-counter: loads a value, counts toward zero and holds there.
module seq_downcounter #(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] value_i,
  output logic                 zero_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/target_power_sequencer.sv
// Register-controlled power-cycle / reset-pulse sequencer driving target
// power and nRST, with an optional one-shot arm pulse when the run completes.
module target_power_sequencer
  import target_seq_pkg::*;
#(
  parameter logic [5:0] REG_ADDR  = 6'd50,
  parameter int         CNT_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  output logic        target_npower_o,
  output logic        output_nrst_o,
  output logic        enable_output_nrst_o,
  output logic        busy_o,
  output logic        arm_o
);

  seq_state_e state_q, state_d;

  logic               pwrcycle_q, arm_after_q;
  logic               start_q, abort_q;
  logic               done_q, aborted_q;
  logic [FIELD_W-1:0] off_q, settle_q, rst_q;
  logic [FIELD_W-1:0] off_sh_q, settle_sh_q, rst_sh_q;

  logic               npower_q, npower_d;
  logic               nrst_q, nrst_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               arm_q, arm_d;

  logic               done_set, aborted_set;
  logic               cnt_load, cnt_zero;
  logic [FIELD_W-1:0] cnt_value;

  logic wr_sel, ctrl_wr, start_accept;

  assign wr_sel  = reg_write && reg_addrvalid && (reg_address == REG_ADDR);
  assign ctrl_wr = wr_sel && (reg_bytecnt == BYTE_CTRL);
  // Accepting START only when idle and with no run already pending keeps shadows stable.
  assign start_accept = ctrl_wr && reg_datai[CTRL_START] && !reg_datai[CTRL_ABORT]
                        && (state_q == ST_IDLE) && !start_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      pwrcycle_q  <= 1'b0;
      arm_after_q <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      off_q       <= '0;
      settle_q    <= '0;
      rst_q       <= '0;
      off_sh_q    <= '0;
      settle_sh_q <= '0;
      rst_sh_q    <= '0;
    end else begin
      start_q <= start_accept;
      abort_q <= ctrl_wr && reg_datai[CTRL_ABORT];
      if (start_accept) begin
        off_sh_q    <= off_q;
        settle_sh_q <= settle_q;
        rst_sh_q    <= rst_q;
      end
      if (wr_sel) begin
        case (reg_bytecnt)
          BYTE_CTRL: begin
            pwrcycle_q  <= reg_datai[CTRL_PWRCYCLE];
            arm_after_q <= reg_datai[CTRL_ARM_AFTER];
          end
          BYTE_OFF:            off_q[7:0]      <= reg_datai;
          BYTE_OFF + 16'd1:    off_q[15:8]     <= reg_datai;
          BYTE_OFF + 16'd2:    off_q[23:16]    <= reg_datai;
          BYTE_SETTLE:         settle_q[7:0]   <= reg_datai;
          BYTE_SETTLE + 16'd1: settle_q[15:8]  <= reg_datai;
          BYTE_SETTLE + 16'd2: settle_q[23:16] <= reg_datai;
          BYTE_RST:            rst_q[7:0]      <= reg_datai;
          BYTE_RST + 16'd1:    rst_q[15:8]     <= reg_datai;
          BYTE_RST + 16'd2:    rst_q[23:16]    <= reg_datai;
          default: ;
        endcase
      end
    end
  end

  // Sticky flags: a completion event wins over a simultaneous CTRL-write clear.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (done_set)     done_q <= 1'b1;
      else if (ctrl_wr) done_q <= 1'b0;
      if (aborted_set)  aborted_q <= 1'b1;
      else if (ctrl_wr) aborted_q <= 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      npower_q <= 1'b0;
      nrst_q   <= 1'b1;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      npower_q <= npower_d;
      nrst_q   <= nrst_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      arm_q    <= arm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_value   = '0;
    done_set    = 1'b0;
    aborted_set = 1'b0;
    arm_d       = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start_q && !abort_q) begin
        cnt_load = 1'b1;
        if (pwrcycle_q) begin
          state_d   = ST_PWR_OFF;
          cnt_value = load_value(off_sh_q);
        end else begin
          state_d   = ST_RST_HOLD;
          cnt_value = load_value(rst_sh_q);
        end
      end
    end else if (abort_q) begin
      state_d     = ST_IDLE;
      aborted_set = 1'b1;
    end else if (cnt_zero) begin
      case (state_q)
        ST_PWR_OFF: begin
          state_d   = ST_SETTLE;
          cnt_load  = 1'b1;
          cnt_value = load_value(settle_sh_q);
        end
        ST_SETTLE: begin
          state_d   = ST_RST_HOLD;
          cnt_load  = 1'b1;
          cnt_value = load_value(rst_sh_q);
        end
        default: begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
          arm_d    = arm_after_q;
        end
      endcase
    end
  end

  always_comb begin
    npower_d = (state_d == ST_PWR_OFF);
    en_d     = (state_d != ST_IDLE);
    nrst_d   = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

  seq_downcounter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset_i (reset_i),
    .load_i  (cnt_load),
    .value_i (CNT_WIDTH'(cnt_value)),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    reg_datao = 8'h00;
    if (reg_read && (reg_address == REG_ADDR)) begin
      case (reg_bytecnt)
        BYTE_CTRL:           reg_datao = {4'b0000, arm_after_q, pwrcycle_q, 2'b00};
        BYTE_STATUS:         reg_datao = {1'b0, aborted_q, done_q, busy_q, 1'b0, state_q};
        BYTE_OFF:            reg_datao = off_q[7:0];
        BYTE_OFF + 16'd1:    reg_datao = off_q[15:8];
        BYTE_OFF + 16'd2:    reg_datao = off_q[23:16];
        BYTE_SETTLE:         reg_datao = settle_q[7:0];
        BYTE_SETTLE + 16'd1: reg_datao = settle_q[15:8];
        BYTE_SETTLE + 16'd2: reg_datao = settle_q[23:16];
        BYTE_RST:            reg_datao = rst_q[7:0];
        BYTE_RST + 16'd1:    reg_datao = rst_q[15:8];
        BYTE_RST + 16'd2:    reg_datao = rst_q[23:16];
        default:             reg_datao = 8'h00;
      endcase
    end
  end

  assign reg_hyplen = (reg_hypaddress == REG_ADDR) ? REG_LEN : 16'd0;

  assign target_npower_o      = npower_q;
  assign output_nrst_o        = nrst_q;
  assign enable_output_nrst_o = en_q;
  assign busy_o               = busy_q;
  assign arm_o                = arm_q;

endmodule

// File: tb/tb_target_power_sequencer.sv
// Directed bench for target_power_sequencer: register table plus hand-written
// multi-cycle sequences (full run, reset-only, abort, busy, large count).
module tb_target_power_sequencer;

  localparam logic [5:0] ADDR = 6'd50;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic        target_npower_o, output_nrst_o, enable_output_nrst_o, busy_o, arm_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  target_power_sequencer #(.REG_ADDR(ADDR), .CNT_WIDTH(24)) dut (
    .clk(clk), .reset_i(reset_i),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
    .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid), .reg_hypaddress(reg_hypaddress), .reg_hyplen(reg_hyplen),
    .target_npower_o(target_npower_o), .output_nrst_o(output_nrst_o),
    .enable_output_nrst_o(enable_output_nrst_o), .busy_o(busy_o), .arm_o(arm_o)
  );

  typedef struct {
    bit          wr;
    logic [15:0] bytecnt;
    logic [7:0]  data;
    logic [7:0]  exp;
  } reg_vec_t;

  reg_vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic reg_wr(input logic [15:0] b, input logic [7:0] d, input bit valid = 1'b1);
    @(negedge clk);
    reg_address   = ADDR;
    reg_bytecnt   = b;
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = valid;
    @(posedge clk);
    #1;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] b, output logic [7:0] d);
    reg_address = ADDR;
    reg_bytecnt = b;
    reg_read    = 1'b1;
    #1;
    d = reg_datao;
    reg_read = 1'b0;
  endtask

  task automatic set_fields(input logic [23:0] off, input logic [23:0] settle, input logic [23:0] rst);
    for (int i = 0; i < 3; i++) begin
      reg_wr(16'(2 + i), off[8*i +: 8]);
      reg_wr(16'(5 + i), settle[8*i +: 8]);
      reg_wr(16'(8 + i), rst[8*i +: 8]);
    end
  endtask

  // Samples once per cycle starting right after a START write edge (t=0).
  task automatic run_monitor(input int budget, output int np, output int low, output int arms,
                             output int first_busy, output int last_busy, output int arm_t,
                             output int arm_busy, output bit timeout);
    np = 0; low = 0; arms = 0; first_busy = -1; last_busy = -1; arm_t = -1;
    arm_busy = 0; timeout = 1'b1;
    for (int t = 0; t < budget; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      if (target_npower_o) np++;
      if (enable_output_nrst_o && !output_nrst_o && !target_npower_o) low++;
      if (arm_o) begin
        arms++;
        arm_t = t;
        if (busy_o) arm_busy++;
      end
      if (busy_o) begin
        if (first_busy < 0) first_busy = t;
        last_busy = t;
      end
      if (first_busy >= 0 && !busy_o && t > last_busy + 2) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  logic [7:0] rd;
  int np, low, arms, fb, lb, at, ab;
  bit to;

  initial begin
    vecs[0]  = '{1'b1, 16'd2,  8'h5A, 8'h5A};
    vecs[1]  = '{1'b1, 16'd3,  8'hA5, 8'hA5};
    vecs[2]  = '{1'b1, 16'd4,  8'h3C, 8'h3C};
    vecs[3]  = '{1'b1, 16'd5,  8'h01, 8'h01};
    vecs[4]  = '{1'b1, 16'd7,  8'hFE, 8'hFE};
    vecs[5]  = '{1'b1, 16'd8,  8'h77, 8'h77};
    vecs[6]  = '{1'b1, 16'd10, 8'h80, 8'h80};
    vecs[7]  = '{1'b0, 16'd6,  8'h00, 8'h00};
    vecs[8]  = '{1'b1, 16'd11, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 16'd15, 8'h12, 8'h00};
    vecs[10] = '{1'b1, 16'd1,  8'hFF, 8'h00};
    vecs[11] = '{1'b1, 16'd0,  8'hF0, 8'h00};
    vecs[12] = '{1'b1, 16'd0,  8'h0C, 8'h0C};
    vecs[13] = '{1'b0, 16'd2,  8'h00, 8'h5A};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_npower", target_npower_o, 1'b0);
    check("rst_nrst", output_nrst_o, 1'b1);
    check("rst_en", enable_output_nrst_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_arm", arm_o, 1'b0);
    check("rst_datao_noread", reg_datao, 8'h00);
    reg_hypaddress = ADDR;
    #1 check("hyplen_hit", reg_hyplen, 16'd11);
    reg_hypaddress = 6'd49;
    #1 check("hyplen_miss", reg_hyplen, 16'd0);
    reg_rd(16'd1, rd);
    check("rst_status", rd, 8'h00);
    @(negedge clk);
    reset_i = 1'b0;

    // Register table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) reg_wr(vecs[i].bytecnt, vecs[i].data);
      reg_rd(vecs[i].bytecnt, rd);
      check($sformatf("reg_vec%0d_byte%0d", i, vecs[i].bytecnt), rd, vecs[i].exp);
    end
    reg_wr(16'd2, 8'h99, 1'b0);
    reg_rd(16'd2, rd);
    check("wr_no_addrvalid", rd, 8'h5A);
    reg_address = 6'd49; reg_bytecnt = 16'd2; reg_read = 1'b1;
    #1 check("rd_other_addr", reg_datao, 8'h00);
    reg_read = 1'b0;

    // Full sequence
    set_fields(24'd10, 24'd5, 24'd3);
    reg_wr(16'd0, 8'h0D);
    run_monitor(200, np, low, arms, fb, lb, at, ab, to);
    check("full_timeout", to, 1'b0);
    check("full_first_busy", fb, 1);
    check("full_npower_cycles", np, 10);
    check("full_nrst_low_cycles", low, 8);
    check("full_arm_count", arms, 1);
    check("full_arm_time", at, 19);
    check("full_arm_after_busy", at, lb + 1);
    check("full_arm_while_busy", ab, 0);
    reg_rd(16'd1, rd);
    check("full_status", rd, 8'h20);

    // Reset-only run
    set_fields(24'd10, 24'd5, 24'd0);
    reg_wr(16'd0, 8'h01);
    run_monitor(100, np, low, arms, fb, lb, at, ab, to);
    check("ronly_timeout", to, 1'b0);
    check("ronly_npower_cycles", np, 0);
    check("ronly_nrst_low_cycles", low, 1);
    check("ronly_arm_count", arms, 0);
    reg_rd(16'd1, rd);
    check("ronly_status", rd, 8'h20);

    // Abort during SETTLE
    set_fields(24'd10, 24'd5, 24'd3);
    reg_wr(16'd0, 8'h0D);
    repeat (12) @(posedge clk);
    #1;
    reg_rd(16'd1, rd);
    check("abort_settle_status", rd, 8'h12);
    reg_wr(16'd0, 8'h0E);
    check("abort_still_busy", busy_o, 1'b1);
    run_monitor(10, np, low, arms, fb, lb, at, ab, to);
    check("abort_idle_next_edge", lb, 0);
    check("abort_no_arm", arms, 0);
    check("abort_en_released", enable_output_nrst_o, 1'b0);
    reg_rd(16'd1, rd);
    check("abort_status", rd, 8'h40);

    // START|ABORT together in IDLE
    reg_wr(16'd0, 8'h07);
    run_monitor(6, np, low, arms, fb, lb, at, ab, to);
    check("sa_never_busy", fb, -1);
    check("sa_no_npower", np, 0);
    reg_rd(16'd1, rd);
    check("sa_status", rd, 8'h00);

    // START mid-run ignored; RST change applies to next run only
    set_fields(24'd0, 24'd0, 24'd3);
    reg_wr(16'd0, 8'h01);
    fork
      run_monitor(50, np, low, arms, fb, lb, at, ab, to);
      begin
        reg_wr(16'd8, 8'd7);
        reg_wr(16'd0, 8'h01);
      end
    join
    check("busy_timeout", to, 1'b0);
    check("busy_run1_low", low, 3);
    check("busy_run1_last", lb, 3);
    reg_wr(16'd0, 8'h01);
    run_monitor(50, np, low, arms, fb, lb, at, ab, to);
    check("busy_run2_low", low, 7);

    // Large count, then reset mid-hold
    set_fields(24'd0, 24'd0, 24'hFFFFFF);
    reg_wr(16'd0, 8'h09);
    repeat (50) @(posedge clk);
    #1;
    check("large_still_holding", {busy_o, enable_output_nrst_o, output_nrst_o}, 3'b110);
    reg_rd(16'd1, rd);
    check("large_status", rd, 8'h13);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_outputs", {target_npower_o, output_nrst_o, enable_output_nrst_o, busy_o, arm_o}, 5'b01000);
    @(negedge clk);
    reset_i = 1'b0;
    run_monitor(5, np, low, arms, fb, lb, at, ab, to);
    check("midrst_no_arm", arms, 0);
    reg_rd(16'd1, rd);
    check("midrst_status", rd, 8'h00);
    reg_rd(16'd8, rd);
    check("midrst_rst_field", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
